// File: rtl/icache_pkg.sv
// Shared cache definitions: FSM encoding, address field positions and block width.
// Kept separate so a later data cache can reuse the same layout.
package icache_pkg;

    typedef logic [1:0] cache_state_t;

    localparam cache_state_t IDLE     = 2'd0;
    localparam cache_state_t MEM_READ = 2'd1;
    localparam cache_state_t UPDATE   = 2'd2;

    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 4;
    localparam int TAG_LSB    = 7;

    localparam int BLOCK_W = 128;

endpackage

// File: rtl/icache_ctrl.sv
// Miss-handling FSM for the instruction cache: request latch, memory handshake,
// fill strobes and saturating hit/miss counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16,
    parameter int BLK_ADDR_W = ADDR_W - INDEX_LSB
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hit,
    input  logic [ADDR_W-1:0]     pc_addr,
    input  logic                  mem_busywait,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [BLK_ADDR_W-1:0] mem_address,
    output logic                  capture_en,
    output logic                  fill_en,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    cache_state_t          state_reg;
    logic [BLK_ADDR_W-1:0] req_addr_reg;
    logic [ADDR_W-1:0]     pc_prev_reg;
    logic                  counted_reg;
    logic [CNT_W-1:0]      hit_count_reg;
    logic [CNT_W-1:0]      miss_count_reg;

    logic pc_same;
    logic count_hit;

    // A fetch is counted once: the flag survives only while PC stays put.
    assign pc_same   = (pc_addr == pc_prev_reg);
    assign count_hit = (state_reg == IDLE) && hit && !(counted_reg && pc_same);

    assign busywait    = (state_reg == IDLE) ? ~hit : 1'b1;
    assign mem_read    = (state_reg == MEM_READ);
    assign capture_en  = mem_read && !mem_busywait;
    assign fill_en     = (state_reg == UPDATE);
    assign mem_address = req_addr_reg;
    assign hit_count   = hit_count_reg;
    assign miss_count  = miss_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            req_addr_reg   <= '0;
            pc_prev_reg    <= '0;
            counted_reg    <= 1'b0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            pc_prev_reg <= pc_addr;
            counted_reg <= count_hit ? 1'b1 : (counted_reg && pc_same);
            case (state_reg)
                IDLE: begin
                    if (!hit) begin
                        req_addr_reg <= pc_addr[ADDR_W-1:INDEX_LSB];
                        state_reg    <= MEM_READ;
                        if (miss_count_reg != '1)
                            miss_count_reg <= miss_count_reg + 1'b1;
                    end else if (count_hit && (hit_count_reg != '1)) begin
                        hit_count_reg <= hit_count_reg + 1'b1;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait)
                        state_reg <= UPDATE;
                end
                UPDATE:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: tag/valid/data arrays with a
// combinational hit path, miss handling delegated to icache_ctrl.
module instruction_cache
    import icache_pkg::BLOCK_W;
    import icache_pkg::OFFSET_LSB;
    import icache_pkg::INDEX_LSB;
    import icache_pkg::TAG_LSB;
#(
    parameter int BLOCKS          = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_W          = 10,
    parameter int TAG_W           = 3,
    parameter int CNT_W           = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [31:0]                 PC,
    output logic [31:0]                 INSTRUCTION,
    output logic                        BUSYWAIT,
    output logic                        MEM_READ,
    output logic [ADDR_W-INDEX_LSB-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]          MEM_READDATA,
    input  logic                        MEM_BUSYWAIT,
    output logic [CNT_W-1:0]            HIT_COUNT,
    output logic [CNT_W-1:0]            MISS_COUNT
);

    localparam int IDX_W      = $clog2(BLOCKS);
    localparam int OFF_W      = $clog2(WORDS_PER_BLOCK);
    localparam int BLK_ADDR_W = ADDR_W - INDEX_LSB;

    logic [ADDR_W-1:0] pc_addr;
    logic [OFF_W-1:0]  pc_offset;
    logic [IDX_W-1:0]  pc_index;
    logic [TAG_W-1:0]  pc_tag;
    logic              unused_pc;

    logic [BLOCKS-1:0]  valid_reg;
    logic [TAG_W-1:0]   tag_array [BLOCKS];
    logic [BLOCK_W-1:0] data_array [BLOCKS];
    logic [BLOCK_W-1:0] fill_data_reg;

    logic                  hit;
    logic                  capture_en;
    logic                  fill_en;
    logic [BLK_ADDR_W-1:0] req_addr;
    logic [IDX_W-1:0]      fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic [BLOCKS-1:0]     fill_sel;

    assign pc_addr   = PC[ADDR_W-1:0];
    assign unused_pc = ^PC[31:ADDR_W];
    assign pc_offset = pc_addr[INDEX_LSB-1:OFFSET_LSB];
    assign pc_index  = pc_addr[TAG_LSB-1:INDEX_LSB];
    assign pc_tag    = pc_addr[ADDR_W-1:TAG_LSB];

    assign hit         = valid_reg[pc_index] && (tag_array[pc_index] == pc_tag);
    assign INSTRUCTION = hit ? data_array[pc_index][{pc_offset, 5'b0} +: 32] : 32'h0;

    // The fill always targets the latched request, never the live PC.
    assign fill_index  = req_addr[IDX_W-1:0];
    assign fill_tag    = req_addr[BLK_ADDR_W-1:IDX_W];
    assign MEM_ADDRESS = req_addr;

    for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_fill_sel
        assign fill_sel[gi] = fill_en && (fill_index == IDX_W'(gi));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            valid_reg <= '0;
        else
            valid_reg <= valid_reg | fill_sel;
    end

    always_ff @(posedge CLK) begin
        if (capture_en)
            fill_data_reg <= MEM_READDATA;
        if (fill_en) begin
            data_array[fill_index] <= fill_data_reg;
            tag_array[fill_index]  <= fill_tag;
        end
    end

    icache_ctrl #(
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .BLK_ADDR_W (BLK_ADDR_W)
    ) u_ctrl (
        .clk          (CLK),
        .rst_n        (RESET),
        .hit          (hit),
        .pc_addr      (pc_addr),
        .mem_busywait (MEM_BUSYWAIT),
        .busywait     (BUSYWAIT),
        .mem_read     (MEM_READ),
        .mem_address  (req_addr),
        .capture_en   (capture_en),
        .fill_en      (fill_en),
        .hit_count    (HIT_COUNT),
        .miss_count   (MISS_COUNT)
    );

endmodule
